// File: rtl/div_result_buffer.sv
// -----------------------------------------------------------------------------
// div_result_buffer
//
// Purpose:
//   Result FIFO placed behind a pipelined divider that cannot be stalled.
//   Results are captured when the divider reports data_valid, then handed to
//   the consumer over a valid/ready handshake. A credit counter tracks the
//   operations still inside the divider. issue_ok is raised only when every
//   in-flight result is guaranteed a free FIFO slot.
//
// Ports:
//   clk           rising-edge clock
//   rst_n         asynchronous, active-low reset
//   issue         one divider operation started this cycle
//   div_valid     divider result present this cycle
//   div_quotient  divider quotient (WIDTH bits)
//   div_by_zero   divider divide-by-zero flag
//   out_valid     head entry available to the consumer (registered)
//   out_ready     consumer accepts the head entry
//   out_quotient  head entry quotient (registered)
//   out_dbz       head entry divide-by-zero flag (registered)
//   issue_ok      upstream may assert issue next cycle (registered)
//   count         FIFO occupancy (CW bits)
//   ovf_err       sticky error: credit violation, dropped or unmatched result
//
// Configuration:
//   DIV_RESULT_DBZ_SAT_EN  when defined, a divide-by-zero entry stores the
//                          saturated quotient {1'b0, {WIDTH-1{1'b1}}} instead
//                          of the divider's quotient. out_dbz is unaffected.
// -----------------------------------------------------------------------------
module div_result_buffer #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 8,
  parameter int CW    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             issue,
  input  logic             div_valid,
  input  logic [WIDTH-1:0] div_quotient,
  input  logic             div_by_zero,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_quotient,
  output logic             out_dbz,
  output logic             issue_ok,
  output logic [CW-1:0]    count,
  output logic             ovf_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = WIDTH + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW:0]   DEPTH_C1 = (CW+1)'(DEPTH);

  logic [EW-1:0] mem [DEPTH];

  logic [AW-1:0] wrPtr_q, wrPtr_d;
  logic [AW-1:0] rdPtr_q, rdPtr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [EW-1:0] head_q, head_d;
  logic          outValid_q, outValid_d;
  logic          issueOk_q, issueOk_d;
  logic          ovf_q, ovf_d;

  logic          full;
  logic          pop;
  logic          push;
  logic          drop;
  logic [EW-1:0] wrData;
  logic [CW-1:0] remaining;
  logic [CW:0]   creditSum;

  // Entry format is {dbz, quotient}. The saturating build replaces the
  // quotient of a divide-by-zero result with the largest positive value.
`ifdef DIV_RESULT_DBZ_SAT_EN
  assign wrData = div_by_zero ? {1'b1, 1'b0, {(WIDTH-1){1'b1}}}
                              : {1'b0, div_quotient};
`else
  assign wrData = {div_by_zero, div_quotient};
`endif

  // Next-state logic for the FIFO control, the credit counter and the
  // registered outputs. A full FIFO still accepts a result when the head
  // pops in the same cycle, because the popped slot is the one written.
  always_comb begin
    full       = (count_q == DEPTH_C);
    pop        = outValid_q & out_ready;
    push       = div_valid & (~full | pop);
    drop       = div_valid & full & ~pop;

    wrPtr_d    = push ? wrPtr_q + AW'(1) : wrPtr_q;
    rdPtr_d    = pop  ? rdPtr_q + AW'(1) : rdPtr_q;

    count_d    = count_q;
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end

    // A return with nothing in flight is an unmatched result: flag it and
    // hold at zero. The upper end saturates so repeated credit violations
    // cannot wrap the counter back to a small value.
    inflight_d = inflight_q;
    unique case ({issue, div_valid})
      2'b10:   if (inflight_q != '1) inflight_d = inflight_q + CW'(1);
      2'b01:   if (inflight_q != '0) inflight_d = inflight_q - CW'(1);
      default: inflight_d = inflight_q;
    endcase

    creditSum  = {1'b0, count_d} + {1'b0, inflight_d};
    issueOk_d  = (creditSum < DEPTH_C1);
    outValid_d = (count_d != '0);

    ovf_d      = ovf_q | drop | (issue & ~issueOk_q)
               | (div_valid & (inflight_q == '0));

    // The head register is loaded with whatever will sit at the read pointer
    // after this edge. If entries remain after an optional pop, that entry
    // is already in the array; otherwise the only candidate is the result
    // being written now, which bypasses the array to keep latency at one.
    remaining  = count_q - CW'(pop);
    head_d     = head_q;
    if (remaining != '0) begin
      head_d = mem[rdPtr_d];
    end else if (push) begin
      head_d = wrData;
    end
  end

  // Storage array carries no reset; validity comes from the control state.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wrPtr_q] <= wrData;
    end
  end

  // Control state and registered outputs. Reset discards buffered and
  // in-flight results and reopens the issue credit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      inflight_q <= '0;
      head_q     <= '0;
      outValid_q <= 1'b0;
      issueOk_q  <= 1'b1;
      ovf_q      <= 1'b0;
    end else begin
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      head_q     <= head_d;
      outValid_q <= outValid_d;
      issueOk_q  <= issueOk_d;
      ovf_q      <= ovf_d;
    end
  end

  assign out_valid    = outValid_q;
  assign out_quotient = head_q[WIDTH-1:0];
  assign out_dbz      = head_q[WIDTH];
  assign issue_ok     = issueOk_q;
  assign count        = count_q;
  assign ovf_err      = ovf_q;

endmodule

// File: tb/tb_div_result_buffer.sv
// -----------------------------------------------------------------------------
// tb_div_result_buffer
//
// Directed bench for div_result_buffer at default parameters (WIDTH=6,
// DEPTH=8, CW=4). Inputs change 1 time unit after each rising edge and
// outputs are sampled at that same point, well away from the next edge.
// Honors DIV_RESULT_DBZ_SAT_EN for the expected divide-by-zero quotient.
// -----------------------------------------------------------------------------
module tb_div_result_buffer;

  logic       clk;
  logic       rst_n;
  logic       issue;
  logic       div_valid;
  logic [5:0] div_quotient;
  logic       div_by_zero;
  logic       out_valid;
  logic       out_ready;
  logic [5:0] out_quotient;
  logic       out_dbz;
  logic       issue_ok;
  logic [3:0] count;
  logic       ovf_err;

  int nCompared;
  int nMismatched;

`ifdef DIV_RESULT_DBZ_SAT_EN
  localparam logic [5:0] DBZ_Q = 6'h1F;
`else
  localparam logic [5:0] DBZ_Q = 6'h3A;
`endif

  typedef struct {
    logic       issue;
    logic       dv;
    logic [5:0] q;
    logic       dbz;
    logic       rdy;
    logic       eValid;
    logic [5:0] eQ;
    logic       eDbz;
    logic       eIok;
    logic [3:0] eCnt;
    logic       eOvf;
  } vec_t;

  vec_t       vecs [14];
  logic [5:0] expQ [8];

  div_result_buffer #(
    .WIDTH(6),
    .DEPTH(8),
    .CW(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .issue(issue),
    .div_valid(div_valid),
    .div_quotient(div_quotient),
    .div_by_zero(div_by_zero),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_quotient(out_quotient),
    .out_dbz(out_dbz),
    .issue_ok(issue_ok),
    .count(count),
    .ovf_err(ovf_err)
  );

  // 10-unit clock period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the run always ends, even if a sequence stalls.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkField(input string tag, input int act, input int exp);
    nCompared++;
    if (act != exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then return 1 unit after the capturing edge.
  task automatic applyStimulus(input logic iIssue, input logic iDv,
                               input logic [5:0] iQ, input logic iDbz,
                               input logic iRdy);
    issue        = iIssue;
    div_valid    = iDv;
    div_quotient = iQ;
    div_by_zero  = iDbz;
    out_ready    = iRdy;
    @(posedge clk);
    #1;
  endtask

  // Quotient and dbz are only meaningful when out_valid is expected high.
  task automatic checkOutput(input string tag, input logic eValid,
                             input logic [5:0] eQ, input logic eDbz,
                             input logic eIok, input logic [3:0] eCnt,
                             input logic eOvf);
    checkField({tag, " valid"}, int'(out_valid), int'(eValid));
    checkField({tag, " issue_ok"}, int'(issue_ok), int'(eIok));
    checkField({tag, " count"}, int'(count), int'(eCnt));
    checkField({tag, " ovf"}, int'(ovf_err), int'(eOvf));
    if (eValid) begin
      checkField({tag, " quot"}, int'(out_quotient), int'(eQ));
      checkField({tag, " dbz"}, int'(out_dbz), int'(eDbz));
    end
  endtask

  task automatic doReset(input string tag);
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 6'h00, 1'b0, 1'b0);
    checkOutput(tag, 1'b0, 6'h00, 1'b0, 1'b1, 4'd0, 1'b0);
    checkField({tag, " quot"}, int'(out_quotient), 0);
    checkField({tag, " dbz"}, int'(out_dbz), 0);
    rst_n = 1'b1;
  endtask

  initial begin
    nCompared    = 0;
    nMismatched  = 0;
    rst_n        = 1'b0;
    issue        = 1'b0;
    div_valid    = 1'b0;
    div_quotient = 6'h00;
    div_by_zero  = 1'b0;
    out_ready    = 1'b0;

    //            issue dv    q      dbz   rdy  | valid q      dbz   iok   cnt   ovf
    vecs[0]  = '{1'b1, 1'b0, 6'h00, 1'b0, 1'b0, 1'b0, 6'h00, 1'b0, 1'b1, 4'd0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 6'h00, 1'b0, 1'b0, 1'b0, 6'h00, 1'b0, 1'b1, 4'd0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 6'h00, 1'b0, 1'b0, 1'b0, 6'h00, 1'b0, 1'b1, 4'd0, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 6'h05, 1'b0, 1'b0, 1'b1, 6'h05, 1'b0, 1'b1, 4'd1, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 6'h2A, 1'b0, 1'b0, 1'b1, 6'h05, 1'b0, 1'b1, 4'd2, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 6'h00, 1'b0, 1'b1, 1'b1, 6'h2A, 1'b0, 1'b1, 4'd1, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 6'h11, 1'b0, 1'b1, 1'b1, 6'h11, 1'b0, 1'b1, 4'd1, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 6'h00, 1'b0, 1'b1, 1'b0, 6'h00, 1'b0, 1'b1, 4'd0, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 6'h00, 1'b0, 1'b0, 1'b0, 6'h00, 1'b0, 1'b1, 4'd0, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 6'h3F, 1'b0, 1'b1, 1'b1, 6'h3F, 1'b0, 1'b1, 4'd1, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 6'h00, 1'b0, 1'b0, 1'b1, 6'h3F, 1'b0, 1'b1, 4'd1, 1'b0};
    vecs[11] = '{1'b1, 1'b1, 6'h07, 1'b0, 1'b1, 1'b1, 6'h07, 1'b0, 1'b1, 4'd1, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 6'h00, 1'b0, 1'b1, 1'b1, 6'h00, 1'b0, 1'b1, 4'd1, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 6'h00, 1'b0, 1'b1, 1'b0, 6'h00, 1'b0, 1'b1, 4'd0, 1'b0};

    doReset("reset");

    // Mixed push/pop patterns, including push and pop into an empty-after-pop
    // FIFO and an issue coinciding with a return.
    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].issue, vecs[i].dv, vecs[i].q, vecs[i].dbz, vecs[i].rdy);
      checkOutput($sformatf("vec%0d", i), vecs[i].eValid, vecs[i].eQ,
                  vecs[i].eDbz, vecs[i].eIok, vecs[i].eCnt, vecs[i].eOvf);
    end

    // Single op: issue at cycle 0, result at cycle 9, visible for one cycle.
    for (int cyc = 0; cyc < 12; cyc++) begin
      applyStimulus(cyc == 0, cyc == 9, (cyc == 9) ? 6'h05 : 6'h00, 1'b0, 1'b1);
      checkField($sformatf("single c%0d valid", cyc), int'(out_valid), (cyc == 9) ? 1 : 0);
      checkField($sformatf("single c%0d count", cyc), int'(count), (cyc == 9) ? 1 : 0);
      if (cyc == 9) begin
        checkField("single quot", int'(out_quotient), 'h05);
      end
    end
    checkField("single issue_ok", int'(issue_ok), 1);
    checkField("single ovf", int'(ovf_err), 0);

    // Credit limit: issue_ok drops right after the eighth issue.
    for (int k = 1; k <= 8; k++) begin
      applyStimulus(1'b1, 1'b0, 6'h00, 1'b0, 1'b0);
      checkField($sformatf("credit issue%0d issue_ok", k), int'(issue_ok), (k < 8) ? 1 : 0);
    end
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 1'b1, 6'h10 + 6'(i), 1'b0, 1'b0);
      checkOutput($sformatf("credit ret%0d", i), 1'b1, 6'h10, 1'b0, 1'b0,
                  4'(i + 1), 1'b0);
    end
    applyStimulus(1'b0, 1'b0, 6'h00, 1'b0, 1'b1);
    checkOutput("credit pop", 1'b1, 6'h11, 1'b0, 1'b1, 4'd7, 1'b0);

    // Refill to full legally: one issue, one return.
    applyStimulus(1'b1, 1'b0, 6'h00, 1'b0, 1'b0);
    checkOutput("refill issue", 1'b1, 6'h11, 1'b0, 1'b0, 4'd7, 1'b0);
    applyStimulus(1'b0, 1'b1, 6'h20, 1'b0, 1'b0);
    checkOutput("refill full", 1'b1, 6'h11, 1'b0, 1'b0, 4'd8, 1'b0);

    // Push and pop at full. A full buffer means no credit is outstanding, so
    // this return is unmatched and raises the sticky flag; it must still be
    // stored, count must stay 8 and the head must advance.
    applyStimulus(1'b0, 1'b1, 6'h21, 1'b0, 1'b1);
    checkOutput("full pushpop", 1'b1, 6'h12, 1'b0, 1'b0, 4'd8, 1'b1);
    expQ[0] = 6'h12; expQ[1] = 6'h13; expQ[2] = 6'h14; expQ[3] = 6'h15;
    expQ[4] = 6'h16; expQ[5] = 6'h17; expQ[6] = 6'h20; expQ[7] = 6'h21;
    for (int i = 0; i < 8; i++) begin
      checkField($sformatf("full drain%0d quot", i), int'(out_quotient), int'(expQ[i]));
      applyStimulus(1'b0, 1'b0, 6'h00, 1'b0, 1'b1);
    end
    checkOutput("full drained", 1'b0, 6'h00, 1'b0, 1'b1, 4'd0, 1'b1);

    doReset("reset2");

    // Forced overflow: a ninth issue with no credit, then a dropped return.
    for (int k = 1; k <= 8; k++) begin
      applyStimulus(1'b1, 1'b0, 6'h00, 1'b0, 1'b0);
    end
    checkOutput("ovf credit out", 1'b0, 6'h00, 1'b0, 1'b0, 4'd0, 1'b0);
    applyStimulus(1'b1, 1'b0, 6'h00, 1'b0, 1'b0);
    checkOutput("ovf issue", 1'b0, 6'h00, 1'b0, 1'b0, 4'd0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 6'h00, 1'b0, 1'b0);
      checkField($sformatf("ovf sticky%0d", i), int'(ovf_err), 1);
    end
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1'b0, 1'b1, 6'h30 + 6'(i), 1'b0, 1'b0);
    end
    checkOutput("drop", 1'b1, 6'h30, 1'b0, 1'b0, 4'd8, 1'b1);
    for (int i = 0; i < 8; i++) begin
      checkField($sformatf("drop drain%0d quot", i), int'(out_quotient), 'h30 + i);
      applyStimulus(1'b0, 1'b0, 6'h00, 1'b0, 1'b1);
    end
    checkOutput("drop drained", 1'b0, 6'h00, 1'b0, 1'b1, 4'd0, 1'b1);

    doReset("ovf clear");

    // Divide-by-zero entry followed by a normal entry with the same quotient.
    applyStimulus(1'b1, 1'b0, 6'h00, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 6'h00, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 6'h3A, 1'b1, 1'b0);
    checkOutput("dbz entry", 1'b1, DBZ_Q, 1'b1, 1'b1, 4'd1, 1'b0);
    applyStimulus(1'b0, 1'b1, 6'h3A, 1'b0, 1'b0);
    checkOutput("dbz hold", 1'b1, DBZ_Q, 1'b1, 1'b1, 4'd2, 1'b0);
    applyStimulus(1'b0, 1'b0, 6'h00, 1'b0, 1'b1);
    checkOutput("dbz next", 1'b1, 6'h3A, 1'b0, 1'b1, 4'd1, 1'b0);
    applyStimulus(1'b0, 1'b0, 6'h00, 1'b0, 1'b1);
    checkOutput("dbz empty", 1'b0, 6'h00, 1'b0, 1'b1, 4'd0, 1'b0);

    // Reset mid-stream with count=3 and inflight=2.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b0, 6'h00, 1'b0, 1'b0);
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 6'h20 + 6'(i), 1'b0, 1'b0);
    end
    checkOutput("midrst before", 1'b1, 6'h20, 1'b0, 1'b1, 4'd3, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst async", 1'b0, 6'h00, 1'b0, 1'b1, 4'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 6'h00, 1'b0, 1'b0);
    checkOutput("midrst next", 1'b0, 6'h00, 1'b0, 1'b1, 4'd0, 1'b0);
    rst_n = 1'b1;

    // First edge after release accepts work; stale credit must be gone.
    applyStimulus(1'b1, 1'b0, 6'h00, 1'b0, 1'b0);
    checkOutput("post issue", 1'b0, 6'h00, 1'b0, 1'b1, 4'd0, 1'b0);
    applyStimulus(1'b0, 1'b1, 6'h2B, 1'b0, 1'b0);
    checkOutput("post result", 1'b1, 6'h2B, 1'b0, 1'b1, 4'd1, 1'b0);
    applyStimulus(1'b0, 1'b0, 6'h00, 1'b0, 1'b1);
    checkOutput("post pop", 1'b0, 6'h00, 1'b0, 1'b1, 4'd0, 1'b0);
    for (int k = 1; k <= 7; k++) begin
      applyStimulus(1'b1, 1'b0, 6'h00, 1'b0, 1'b0);
    end
    checkOutput("post credit", 1'b0, 6'h00, 1'b0, 1'b1, 4'd0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
